// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame format and default bit period.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  localparam int   UART_DATA_BITS       = 8;
  localparam logic UART_IDLE_LEVEL      = 1'b1;
  localparam int   UART_BIT_CNT_DEFAULT = 100000;

endpackage

// File: rtl/uart_recv_if.sv
// Receive-side signal bundle: serial line in, framed byte and status pulses out.
interface uart_recv_if;
  import uart_pkg::*;

  logic                      din;
  logic [UART_DATA_BITS-1:0] data;
  logic                      valid;
  logic                      frame_err;
  logic                      busy;

  modport master (output din, input data, valid, frame_err, busy);
  modport slave  (input din, output data, valid, frame_err, busy);

endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter that pulses expire for one cycle, load_val cycles after a load.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BIT_CNT = UART_BIT_CNT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [$clog2(BIT_CNT+1)-1:0] load_val,
  output logic                         expire
);

  localparam int W = $clog2(BIT_CNT + 1);

  logic [W-1:0] cnt_r;
  logic         run_r;

  // Counter parks at zero and stops once it has expired, so an idle timer never re-fires.
  assign expire = run_r && (cnt_r == {W{1'b0}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
      run_r <= 1'b0;
    end else if (load) begin
      cnt_r <= load_val - W'(1);
      run_r <= 1'b1;
    end else if (expire) begin
      run_r <= 1'b0;
    end else if (run_r) begin
      cnt_r <= cnt_r - W'(1);
    end
  end

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: synchronizes the line, frames start/data/stop bits mid-bit,
// and reports each good byte with a valid pulse or a bad stop bit with frame_err.
module uart_recv
  import uart_pkg::*;
#(
  parameter int BIT_CNT  = UART_BIT_CNT_DEFAULT,
  parameter int HALF_CNT = BIT_CNT / 2
) (
  input logic        clk,
  input logic        rst,
  uart_recv_if.slave bus
);

  localparam int TW = $clog2(BIT_CNT + 1);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(BIT_CNT);
  localparam logic [TW-1:0] HALF_LOAD = TW'(HALF_CNT);

  logic                      rx_meta, rx_s, rx_d;
  uart_state_t               state, next_state;
  logic [UART_DATA_BITS-1:0] shreg, data_r;
  logic [IW-1:0]             bit_idx;
  logic                      valid_r, frame_err_r, busy_r;
  logic                      expire, tmr_load;
  logic [TW-1:0]             tmr_val;
  logic                      start_edge, last_bit;
  logic                      shift_en, idx_clr, take_byte, flag_err;

  assign start_edge = (rx_d == UART_IDLE_LEVEL) && (rx_s != UART_IDLE_LEVEL);
  assign last_bit   = (bit_idx == IW'(UART_DATA_BITS - 1));

  uart_bit_timer #(.BIT_CNT(BIT_CNT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  // Two synchronizer stages, then one delay stage for start-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= UART_IDLE_LEVEL;
      rx_s    <= UART_IDLE_LEVEL;
      rx_d    <= UART_IDLE_LEVEL;
    end else begin
      rx_meta <= bus.din;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start_edge) next_state = ST_START;
        else            next_state = ST_IDLE;
      end
      ST_START: begin
        if (expire) begin
          if (rx_s == UART_IDLE_LEVEL) next_state = ST_IDLE;
          else                         next_state = ST_DATA;
        end else begin
          next_state = ST_START;
        end
      end
      ST_DATA: begin
        if (expire && last_bit) next_state = ST_STOP;
        else                    next_state = ST_DATA;
      end
      ST_STOP: begin
        if (expire) begin
          if (rx_s == UART_IDLE_LEVEL) next_state = ST_IDLE;
          else                         next_state = ST_BREAK;
        end else begin
          next_state = ST_STOP;
        end
      end
      // A held-low line must rise before another start edge can be recognised.
      ST_BREAK: begin
        if (rx_s == UART_IDLE_LEVEL) next_state = ST_IDLE;
        else                         next_state = ST_BREAK;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_load  = 1'b0;
    tmr_val   = BIT_LOAD;
    shift_en  = 1'b0;
    idx_clr   = 1'b0;
    take_byte = 1'b0;
    flag_err  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          tmr_load = 1'b1;
          tmr_val  = HALF_LOAD;
        end else begin
          tmr_load = 1'b0;
        end
      end
      ST_START: begin
        if (expire && (rx_s != UART_IDLE_LEVEL)) begin
          tmr_load = 1'b1;
          idx_clr  = 1'b1;
        end else begin
          tmr_load = 1'b0;
        end
      end
      ST_DATA: begin
        if (expire) begin
          tmr_load = 1'b1;
          shift_en = 1'b1;
        end else begin
          shift_en = 1'b0;
        end
      end
      ST_STOP: begin
        if (expire) begin
          if (rx_s == UART_IDLE_LEVEL) take_byte = 1'b1;
          else                         flag_err  = 1'b1;
        end else begin
          take_byte = 1'b0;
        end
      end
      ST_BREAK: tmr_load = 1'b0;
      default:  tmr_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= {UART_DATA_BITS{1'b0}};
      bit_idx     <= {IW{1'b0}};
      data_r      <= {UART_DATA_BITS{1'b0}};
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (shift_en) shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
      if (idx_clr)       bit_idx <= {IW{1'b0}};
      else if (shift_en) bit_idx <= bit_idx + IW'(1);
      if (take_byte) data_r <= shreg;
      valid_r     <= take_byte;
      frame_err_r <= flag_err;
      busy_r      <= (next_state != ST_IDLE);
    end
  end

  assign bus.data      = data_r;
  assign bus.valid     = valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_uart_recv.sv
// Directed plus randomized bench for uart_recv; expected bytes and pulse cycles come
// from the frame timing rules applied to what the bench transmits.
module tb_uart_recv;

  localparam int BIT  = 16;
  localparam int HALF = 8;
  // Line falls at cycle t -> valid/frame_err high at t + 2 (sync) + HALF + 9*BIT + 1.
  localparam int LAT  = 2 + HALF + 9 * BIT + 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   overlap = 0;
  int   t0;
  logic [7:0] last_good;
  logic [7:0] rb;

  int         vq_t[$];
  logic [7:0] vq_d[$];
  int         fq_t[$];
  int         ev_t[$];
  logic [7:0] ev_d[$];
  int         ef_t[$];

  uart_recv_if bus();

  uart_recv #(.BIT_CNT(BIT), .HALF_CNT(HALF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      vq_t.push_back(cyc);
      vq_d.push_back(bus.data);
    end
    if (bus.frame_err === 1'b1) fq_t.push_back(cyc);
    if (bus.valid === 1'b1 && bus.frame_err === 1'b1) overlap++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    bus.din = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Transmit one 8N1 frame with the given bit period and record what must come out.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
    int t;
    t = cyc;
    bus.din = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.din = b[i];
      repeat (per) @(negedge clk);
    end
    bus.din = stop;
    repeat (per) @(negedge clk);
    if (stop) begin
      ev_t.push_back(t + LAT);
      ev_d.push_back(b);
      last_good = b;
    end else begin
      ef_t.push_back(t + LAT);
    end
  endtask

  task automatic check_events(input string tag);
    chk($sformatf("%s_nvalid", tag), 32'(vq_t.size()), 32'(ev_t.size()));
    for (int i = 0; i < ev_t.size() && i < vq_t.size(); i++) begin
      chk($sformatf("%s_vcyc%0d", tag, i), 32'(vq_t[i]), 32'(ev_t[i]));
      chk($sformatf("%s_data%0d", tag, i), 32'(vq_d[i]), 32'(ev_d[i]));
    end
    chk($sformatf("%s_nferr", tag), 32'(fq_t.size()), 32'(ef_t.size()));
    for (int i = 0; i < ef_t.size() && i < fq_t.size(); i++) begin
      chk($sformatf("%s_fcyc%0d", tag, i), 32'(fq_t[i]), 32'(ef_t[i]));
    end
    vq_t.delete(); vq_d.delete(); fq_t.delete();
    ev_t.delete(); ev_d.delete(); ef_t.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.din = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(bus.data), 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_ferr", 32'(bus.frame_err), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    idle(5);

    send_frame(8'hA5, 1'b1, BIT);
    idle(10);
    check_events("single");
    chk("single_hold", 32'(bus.data), 32'hA5);

    send_frame(8'h00, 1'b1, BIT);
    send_frame(8'hFF, 1'b1, BIT);
    send_frame(8'h3C, 1'b1, BIT);
    idle(10);
    if (vq_t.size() == 3) begin
      chk("b2b_gap1", 32'(vq_t[1] - vq_t[0]), 32'd160);
      chk("b2b_gap2", 32'(vq_t[2] - vq_t[1]), 32'd160);
    end else begin
      chk("b2b_count", 32'(vq_t.size()), 32'd3);
    end
    check_events("b2b");

    t0 = cyc;
    bus.din = 1'b0;
    repeat (3) @(negedge clk);
    bus.din = 1'b1;
    while (cyc < t0 + 2 + HALF) @(negedge clk);
    chk("glitch_busy_hi", 32'(bus.busy), 32'h1);
    @(negedge clk);
    chk("glitch_busy_lo", 32'(bus.busy), 32'h0);
    idle(20);
    check_events("glitch");

    send_frame(8'h55, 1'b0, BIT);
    bus.din = 1'b0;
    repeat (40) @(negedge clk);
    chk("break_busy", 32'(bus.busy), 32'h1);
    chk("ferr_data", 32'(bus.data), 32'(last_good));
    check_events("badstop");
    bus.din = 1'b1;
    repeat (4) @(negedge clk);
    chk("break_exit", 32'(bus.busy), 32'h0);
    idle(6);
    send_frame(8'h81, 1'b1, BIT);
    idle(10);
    check_events("after_break");

    rb = 8'h7E;
    bus.din = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.din = rb[i];
      repeat (BIT) @(negedge clk);
    end
    bus.din = rb[4];
    repeat (BIT / 2) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_valid", 32'(bus.valid), 32'h0);
    chk("mid_rst_ferr", 32'(bus.frame_err), 32'h0);
    chk("mid_rst_data", 32'(bus.data), 32'h0);
    @(negedge clk);
    bus.din = 1'b1;
    rst = 1'b0;
    last_good = 8'h00;
    idle(20);
    check_events("reset_mid");
    send_frame(8'h7E, 1'b1, BIT);
    idle(10);
    check_events("after_reset");

    send_frame(8'hC3, 1'b1, BIT + 1);
    idle(30);
    send_frame(8'hC3, 1'b1, BIT - 1);
    idle(30);
    check_events("skew");

    for (int k = 0; k < 8; k++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, BIT);
      idle($urandom_range(0, 4));
    end
    idle(10);
    check_events("random");

    chk("no_overlap", 32'(overlap), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
